// File: rtl/dcache_miss_handler.sv
// rtl/dcache_miss_handler.sv - blocking data-cache miss handler: lookup, block fill, replay, write-through.
// Optional hit/miss counters are built when DCACHE_MISS_HANDLER_PERF_EN is defined.
module dcache_miss_handler #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int BLOCK_SIZE = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req_valid,
    output logic                  core_req_ready,
    input  logic                  core_req_we,
    input  logic [ADDR_W-1:0]     core_req_addr,
    input  logic [DATA_W-1:0]     core_req_wdata,
    output logic                  core_resp_valid,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  cache_r_en,
    output logic [ADDR_W-1:0]     cache_r_addr,
    input  logic                  cache_r_hit,
    input  logic [DATA_W-1:0]     cache_r_data,
    output logic                  cache_w_en,
    output logic [ADDR_W-1:0]     cache_w_addr,
    output logic [DATA_W-1:0]     cache_w_data,
    output logic                  cache_is_repair,
    output logic [BLOCK_SIZE-1:0] cache_repair_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic [DATA_W-1:0]     mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [BLOCK_SIZE-1:0] mem_resp_data,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
);
    localparam int OFF_W  = $clog2(BLOCK_SIZE / 8);
    localparam int WOFF_W = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] BLK_MASK  = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [ADDR_W-1:0] WORD_MASK = {ADDR_W{1'b1}} << WOFF_W;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, MISS_REQ, MISS_WAIT, REPAIR, REPLAY, WT_REQ
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [BLOCK_SIZE-1:0] block_q, block_d;
    logic                  alive_q, alive_d;
    logic                  accept;

    assign accept  = core_req_valid && core_req_ready;
    assign alive_d = 1'b1;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        block_d = block_q;
        case (state_q)
            IDLE: if (accept) begin
                we_d    = core_req_we;
                addr_d  = core_req_addr;
                wdata_d = core_req_wdata;
                state_d = LOOKUP;
            end
            LOOKUP:    state_d = cache_r_hit ? (we_q ? WT_REQ : IDLE) : MISS_REQ;
            MISS_REQ:  if (mem_req_ready) state_d = MISS_WAIT;
            MISS_WAIT: if (mem_resp_valid) begin
                block_d = mem_resp_data;
                state_d = REPAIR;
            end
            REPAIR:    state_d = REPLAY;
            REPLAY:    state_d = LOOKUP;
            WT_REQ:    if (mem_req_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Handshake-facing outputs are decoded from state because hit and accept timing is same-cycle.
    always_comb begin
        core_req_ready    = alive_q && (state_q == IDLE);
        core_resp_valid   = 1'b0;
        core_rdata        = '0;
        cache_r_en        = 1'b0;
        cache_r_addr      = addr_q;
        cache_w_en        = 1'b0;
        cache_w_addr      = addr_q;
        cache_w_data      = wdata_q;
        cache_is_repair   = 1'b0;
        cache_repair_data = block_q;
        mem_req_valid     = 1'b0;
        mem_req_we        = 1'b0;
        mem_req_addr      = '0;
        mem_req_wdata     = '0;
        case (state_q)
            IDLE: begin
                cache_r_en   = accept;
                cache_r_addr = core_req_addr;
            end
            LOOKUP: if (cache_r_hit) begin
                if (we_q) begin
                    cache_w_en = 1'b1;
                end else begin
                    core_resp_valid = 1'b1;
                    core_rdata      = cache_r_data;
                end
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = addr_q & BLK_MASK;
            end
            REPAIR: begin
                cache_w_en      = 1'b1;
                cache_is_repair = 1'b1;
            end
            REPLAY: cache_r_en = 1'b1;
            WT_REQ: begin
                mem_req_valid   = 1'b1;
                mem_req_we      = 1'b1;
                mem_req_addr    = addr_q & WORD_MASK;
                mem_req_wdata   = wdata_q;
                core_resp_valid = mem_req_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            block_q <= '0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            block_q <= block_d;
            alive_q <= alive_d;
        end
    end

`ifdef DCACHE_MISS_HANDLER_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == LOOKUP) begin
            if (cache_r_hit && (hit_cnt_q != '1))
                hit_cnt_d = hit_cnt_q + 32'd1;
            if (!cache_r_hit && (miss_cnt_q != '1))
                miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_miss_handler.sv
// tb/tb_dcache_miss_handler.sv - directed self-checking bench for dcache_miss_handler.
module tb_dcache_miss_handler;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         core_req_valid = 1'b0, core_req_ready, core_req_we = 1'b0;
    logic [31:0]  core_req_addr = '0, core_req_wdata = '0;
    logic         core_resp_valid;
    logic [31:0]  core_rdata;
    logic         cache_r_en, cache_r_hit;
    logic [31:0]  cache_r_addr, cache_r_data;
    logic         cache_w_en, cache_is_repair;
    logic [31:0]  cache_w_addr, cache_w_data;
    logic [127:0] cache_repair_data;
    logic         mem_req_valid, mem_req_ready = 1'b0, mem_req_we;
    logic [31:0]  mem_req_addr, mem_req_wdata;
    logic         mem_resp_valid = 1'b0;
    logic [127:0] mem_resp_data = '0;
    logic [31:0]  hit_cnt_o, miss_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;
    int resp_cnt = 0;
    int repair_cnt = 0;

    logic [127:0] cblk [logic [31:0]];

`ifdef DCACHE_MISS_HANDLER_PERF_EN
    localparam logic [31:0] EXP_HIT1 = 32'd1, EXP_HIT2 = 32'd2, EXP_MISS2 = 32'd1;
`else
    localparam logic [31:0] EXP_HIT1 = 32'd0, EXP_HIT2 = 32'd0, EXP_MISS2 = 32'd0;
`endif

    localparam logic [127:0] FILL_A = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    localparam logic [127:0] FILL_B = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    dcache_miss_handler dut (
        .clk(clk), .rst(rst),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_we(core_req_we), .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
        .core_resp_valid(core_resp_valid), .core_rdata(core_rdata),
        .cache_r_en(cache_r_en), .cache_r_addr(cache_r_addr),
        .cache_r_hit(cache_r_hit), .cache_r_data(cache_r_data),
        .cache_w_en(cache_w_en), .cache_w_addr(cache_w_addr), .cache_w_data(cache_w_data),
        .cache_is_repair(cache_is_repair), .cache_repair_data(cache_repair_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;

    // Behavioural cache: block-tagged store, read data returned one cycle after cache_r_en.
    always @(posedge clk) begin
        logic [31:0]  wkey, rkey;
        logic [127:0] tmp;
        wkey = cache_w_addr & 32'hFFFF_FFF0;
        rkey = cache_r_addr & 32'hFFFF_FFF0;
        if (cache_w_en) begin
            if (cache_is_repair) begin
                cblk[wkey] = cache_repair_data;
            end else if (cblk.exists(wkey)) begin
                tmp = cblk[wkey];
                tmp[int'(cache_w_addr[3:2]) * 32 +: 32] = cache_w_data;
                cblk[wkey] = tmp;
            end
        end
        if (cache_r_en && cblk.exists(rkey)) begin
            tmp = cblk[rkey];
            cache_r_hit  <= 1'b1;
            cache_r_data <= tmp[int'(cache_r_addr[3:2]) * 32 +: 32];
        end else begin
            cache_r_hit  <= 1'b0;
            cache_r_data <= '0;
        end
    end

    always @(posedge clk) begin
        if (core_resp_valid) resp_cnt <= resp_cnt + 1;
        if (cache_w_en && cache_is_repair) repair_cnt <= repair_cnt + 1;
    end

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (core_req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", core_req_ready); end
        n_cmp++; if ({core_resp_valid, cache_r_en, cache_w_en, cache_is_repair, mem_req_valid} !== 5'b0) begin n_bad++; $display("FAIL rst_valids: got %b want 00000", {core_resp_valid, cache_r_en, cache_w_en, cache_is_repair, mem_req_valid}); end
        n_cmp++; if (core_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", core_rdata); end
        n_cmp++; if ({cache_w_addr, cache_w_data, cache_repair_data} !== 192'h0) begin n_bad++; $display("FAIL rst_latched: got %h want 0", {cache_w_addr, cache_w_data, cache_repair_data}); end
        n_cmp++; if ({hit_cnt_o, miss_cnt_o} !== 64'h0) begin n_bad++; $display("FAIL rst_cnt: got %h want 0", {hit_cnt_o, miss_cnt_o}); end
        @(negedge clk); rst = 1'b1; #1;
        n_cmp++; if (core_req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_early: got %b want 0", core_req_ready); end
        @(negedge clk); #1;
        n_cmp++; if (core_req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after: got %b want 1", core_req_ready); end
    endtask

    task automatic test_load_hit;
        cblk[32'h100] = {32'h03030303, 32'h02020202, 32'h01010101, 32'hDEADBEEF};
        @(negedge clk); core_req_valid = 1'b1; core_req_we = 1'b0; core_req_addr = 32'h100; #1;
        n_cmp++; if ({cache_r_en, cache_r_addr} !== {1'b1, 32'h100}) begin n_bad++; $display("FAIL lh_lookup: got %b/%h want 1/00000100", cache_r_en, cache_r_addr); end
        @(negedge clk); #1;
        n_cmp++; if (core_req_ready !== 1'b0) begin n_bad++; $display("FAIL lh_busy_ready: got %b want 0", core_req_ready); end
        core_req_valid = 1'b0; #1;
        n_cmp++; if ({core_resp_valid, core_rdata} !== {1'b1, 32'hDEADBEEF}) begin n_bad++; $display("FAIL lh_resp: got %b/%h want 1/deadbeef", core_resp_valid, core_rdata); end
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL lh_no_mem: got %b want 0", mem_req_valid); end
        @(negedge clk); #1;
        n_cmp++; if ({core_resp_valid, core_req_ready} !== 2'b01) begin n_bad++; $display("FAIL lh_idle: got %b want 01", {core_resp_valid, core_req_ready}); end
        n_cmp++; if ({hit_cnt_o, miss_cnt_o} !== {EXP_HIT1, 32'h0}) begin n_bad++; $display("FAIL lh_cnt: got %0d/%0d want %0d/0", hit_cnt_o, miss_cnt_o, EXP_HIT1); end
    endtask

    task automatic test_load_miss;
        @(negedge clk); core_req_valid = 1'b1; core_req_we = 1'b0; core_req_addr = 32'h204; #1;
        @(negedge clk); core_req_valid = 1'b0; #1;
        n_cmp++; if (core_resp_valid !== 1'b0) begin n_bad++; $display("FAIL lm_no_resp: got %b want 0", core_resp_valid); end
        @(negedge clk); #1;
        n_cmp++; if ({mem_req_valid, mem_req_we, mem_req_addr} !== {2'b10, 32'h200}) begin n_bad++; $display("FAIL lm_req: got %b%b/%h want 10/00000200", mem_req_valid, mem_req_we, mem_req_addr); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_cmp++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h200}) begin n_bad++; $display("FAIL lm_req_hold%0d: got %b/%h want 1/00000200", i, mem_req_valid, mem_req_addr); end
        end
        @(negedge clk); mem_req_ready = 1'b1; #1;
        @(negedge clk); mem_req_ready = 1'b0; #1;
        n_cmp++; if ({mem_req_valid, cache_w_en} !== 2'b00) begin n_bad++; $display("FAIL lm_wait: got %b want 00", {mem_req_valid, cache_w_en}); end
        @(negedge clk); mem_resp_valid = 1'b1; mem_resp_data = FILL_A; #1;
        @(negedge clk); mem_resp_valid = 1'b0; mem_resp_data = '0; #1;
        n_cmp++; if ({cache_w_en, cache_is_repair, cache_w_addr} !== {2'b11, 32'h204}) begin n_bad++; $display("FAIL lm_repair: got %b%b/%h want 11/00000204", cache_w_en, cache_is_repair, cache_w_addr); end
        n_cmp++; if (cache_repair_data !== FILL_A) begin n_bad++; $display("FAIL lm_repair_data: got %h want %h", cache_repair_data, FILL_A); end
        @(negedge clk); #1;
        n_cmp++; if ({cache_r_en, cache_w_en, cache_r_addr} !== {2'b10, 32'h204}) begin n_bad++; $display("FAIL lm_replay: got %b%b/%h want 10/00000204", cache_r_en, cache_w_en, cache_r_addr); end
        @(negedge clk); #1;
        n_cmp++; if ({core_resp_valid, core_rdata} !== {1'b1, 32'hB1B1B1B1}) begin n_bad++; $display("FAIL lm_resp: got %b/%h want 1/b1b1b1b1", core_resp_valid, core_rdata); end
        @(negedge clk); #1;
        n_cmp++; if ({hit_cnt_o, miss_cnt_o} !== {EXP_HIT2, EXP_MISS2}) begin n_bad++; $display("FAIL lm_cnt: got %0d/%0d want %0d/%0d", hit_cnt_o, miss_cnt_o, EXP_HIT2, EXP_MISS2); end
    endtask

    task automatic test_store_hit;
        int r0;
        r0 = resp_cnt;
        @(negedge clk); core_req_valid = 1'b1; core_req_we = 1'b1; core_req_addr = 32'h100; core_req_wdata = 32'h55AA55AA; #1;
        @(negedge clk); core_req_valid = 1'b0; core_req_we = 1'b0; #1;
        n_cmp++; if ({cache_w_en, cache_is_repair, cache_w_addr, cache_w_data} !== {2'b10, 32'h100, 32'h55AA55AA}) begin n_bad++; $display("FAIL sh_cwrite: got %b%b/%h/%h want 10/00000100/55aa55aa", cache_w_en, cache_is_repair, cache_w_addr, cache_w_data); end
        n_cmp++; if ({core_resp_valid, mem_req_valid} !== 2'b00) begin n_bad++; $display("FAIL sh_early: got %b want 00", {core_resp_valid, mem_req_valid}); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            n_cmp++; if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, core_resp_valid, cache_w_en} !== {2'b11, 32'h100, 32'h55AA55AA, 2'b00}) begin n_bad++; $display("FAIL sh_wt_hold%0d: got %b%b/%h/%h/%b%b want 11/00000100/55aa55aa/00", i, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, core_resp_valid, cache_w_en); end
        end
        @(negedge clk); mem_req_ready = 1'b1; #1;
        n_cmp++; if (core_resp_valid !== 1'b1) begin n_bad++; $display("FAIL sh_resp: got %b want 1", core_resp_valid); end
        @(negedge clk); mem_req_ready = 1'b0; #1;
        n_cmp++; if ({core_resp_valid, mem_req_valid, core_req_ready} !== 3'b001) begin n_bad++; $display("FAIL sh_idle: got %b want 001", {core_resp_valid, mem_req_valid, core_req_ready}); end
        n_cmp++; if (resp_cnt - r0 !== 1) begin n_bad++; $display("FAIL sh_resp_count: got %0d want 1", resp_cnt - r0); end
        n_cmp++; if (cblk[32'h100][31:0] !== 32'h55AA55AA) begin n_bad++; $display("FAIL sh_cache_word: got %h want 55aa55aa", cblk[32'h100][31:0]); end
    endtask

    task automatic test_store_miss;
        int r0;
        r0 = resp_cnt;
        @(negedge clk); core_req_valid = 1'b1; core_req_we = 1'b1; core_req_addr = 32'h310; core_req_wdata = 32'h12345678; #1;
        @(negedge clk); core_req_valid = 1'b0; core_req_we = 1'b0; #1;
        n_cmp++; if ({cache_w_en, core_resp_valid} !== 2'b00) begin n_bad++; $display("FAIL sm_miss: got %b want 00", {cache_w_en, core_resp_valid}); end
        @(negedge clk); mem_req_ready = 1'b1; #1;
        n_cmp++; if ({mem_req_valid, mem_req_we, mem_req_addr} !== {2'b10, 32'h310}) begin n_bad++; $display("FAIL sm_fill_req: got %b%b/%h want 10/00000310", mem_req_valid, mem_req_we, mem_req_addr); end
        @(negedge clk); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = FILL_B; #1;
        @(negedge clk); mem_resp_valid = 1'b0; mem_resp_data = '0; #1;
        n_cmp++; if ({cache_w_en, cache_is_repair, cache_repair_data} !== {2'b11, FILL_B}) begin n_bad++; $display("FAIL sm_repair: got %b%b/%h want 11/%h", cache_w_en, cache_is_repair, cache_repair_data, FILL_B); end
        @(negedge clk); #1;
        n_cmp++; if (cache_r_en !== 1'b1) begin n_bad++; $display("FAIL sm_replay: got %b want 1", cache_r_en); end
        @(negedge clk); #1;
        n_cmp++; if ({cache_w_en, cache_is_repair, cache_w_data, core_resp_valid} !== {2'b10, 32'h12345678, 1'b0}) begin n_bad++; $display("FAIL sm_cwrite: got %b%b/%h/%b want 10/12345678/0", cache_w_en, cache_is_repair, cache_w_data, core_resp_valid); end
        @(negedge clk); mem_req_ready = 1'b1; #1;
        n_cmp++; if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, core_resp_valid} !== {2'b11, 32'h310, 32'h12345678, 1'b1}) begin n_bad++; $display("FAIL sm_wt: got %b%b/%h/%h/%b want 11/00000310/12345678/1", mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, core_resp_valid); end
        @(negedge clk); mem_req_ready = 1'b0; #1;
        n_cmp++; if ({core_resp_valid, core_req_ready} !== 2'b01) begin n_bad++; $display("FAIL sm_idle: got %b want 01", {core_resp_valid, core_req_ready}); end
        n_cmp++; if (resp_cnt - r0 !== 1) begin n_bad++; $display("FAIL sm_resp_count: got %0d want 1", resp_cnt - r0); end
        n_cmp++; if (cblk[32'h310][63:0] !== 64'h22222222_12345678) begin n_bad++; $display("FAIL sm_cache_block: got %h want 2222222212345678", cblk[32'h310][63:0]); end
    endtask

    task automatic test_reset_miss_wait;
        int r0, p0;
        @(negedge clk); core_req_valid = 1'b1; core_req_we = 1'b0; core_req_addr = 32'h400; #1;
        @(negedge clk); core_req_valid = 1'b0; #1;
        @(negedge clk); mem_req_ready = 1'b1; #1;
        @(negedge clk); mem_req_ready = 1'b0; #1;
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rw_in_wait: got %b want 0", mem_req_valid); end
        @(negedge clk); rst = 1'b0; #1;
        @(negedge clk); rst = 1'b1; #1;
        r0 = resp_cnt; p0 = repair_cnt;
        n_cmp++; if ({core_req_ready, mem_req_valid} !== 2'b00) begin n_bad++; $display("FAIL rw_after_rst: got %b want 00", {core_req_ready, mem_req_valid}); end
        @(negedge clk); mem_resp_valid = 1'b1; mem_resp_data = FILL_A; #1;
        n_cmp++; if ({core_req_ready, cache_w_en} !== 2'b10) begin n_bad++; $display("FAIL rw_stray: got %b want 10", {core_req_ready, cache_w_en}); end
        @(negedge clk); mem_resp_valid = 1'b0; mem_resp_data = '0; #1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if ({core_req_ready, cache_w_en, cache_is_repair, mem_req_valid, core_resp_valid} !== 5'b10000) begin n_bad++; $display("FAIL rw_idle: got %b want 10000", {core_req_ready, cache_w_en, cache_is_repair, mem_req_valid, core_resp_valid}); end
        n_cmp++; if (cache_repair_data !== 128'h0) begin n_bad++; $display("FAIL rw_block: got %h want 0", cache_repair_data); end
        n_cmp++; if ((repair_cnt - p0) !== 0 || (resp_cnt - r0) !== 0) begin n_bad++; $display("FAIL rw_no_activity: got repair %0d resp %0d want 0/0", repair_cnt - p0, resp_cnt - r0); end
        n_cmp++; if ({hit_cnt_o, miss_cnt_o} !== 64'h0) begin n_bad++; $display("FAIL rw_cnt: got %0d/%0d want 0/0", hit_cnt_o, miss_cnt_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_hit();
        test_load_miss();
        test_store_hit();
        test_store_miss();
        test_reset_miss_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
